// File: rtl/sdram_host_port.sv
// User-side initiator for the SDRAM controller host interface: burst commands, staged write FIFO.
// Optional watchdog abort on stuck bursts is built when SDRAM_HOST_TIMEOUT_EN is defined.
module sdram_host_port #(
  parameter int unsigned DSIZE    = 16,
  parameter int unsigned ASIZE    = 23,
  parameter int unsigned WFIFO_AW = 8,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned TMO_CYC  = 4095
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ASIZE-1:0]   cmd_addr,
  input  logic [7:0]         cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DSIZE-1:0]   wr_data,
  input  logic [DSIZE/8-1:0] wr_mask,
  output logic               rd_valid,
  output logic [DSIZE-1:0]   rd_data,
  output logic               cmd_done,
  output logic               busy,
  output logic               err,
  output logic [ASIZE-1:0]   ctl_addr,
  output logic               ctl_wr,
  output logic               ctl_rd,
  output logic [7:0]         ctl_length,
  output logic [DSIZE-1:0]   ctl_datain,
  output logic [DSIZE/8-1:0] ctl_dm,
  input  logic               ctl_in_req,
  input  logic               ctl_out_valid,
  input  logic [DSIZE-1:0]   ctl_dataout,
  input  logic               ctl_done
);

  localparam int unsigned MW    = DSIZE / 8;
  localparam int unsigned Depth = 1 << WFIFO_AW;
  localparam int unsigned LW    = WFIFO_AW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StRelease, StGap} state_e;

  state_e                  state_q, state_d;
  logic [MW+DSIZE-1:0]     mem_q [Depth];
  logic [WFIFO_AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]           level_q, level_d, flush_n;
  logic [7:0]              sent_q, rcvd_q, gap_q;
  logic                    dir_wr_q, err_q, cmd_done_q, rd_valid_q, ctl_wr_q, ctl_rd_q;
  logic [DSIZE-1:0]        rd_data_q;
  logic [ASIZE-1:0]        ctl_addr_q;
  logic [7:0]              ctl_length_q;
  logic                    accept, push, pop, want_word, starve, rd_take, tmo_hit, fifo_empty;
  logic [MW+DSIZE-1:0]     head;

  assign fifo_empty = (level_q == '0);
  assign wr_ready   = 32'(level_q) < Depth;
  assign cmd_ready  = (state_q == StIdle) && cmd_valid &&
                      (!cmd_write || 32'(level_q) >= 32'(cmd_len));
  assign accept     = cmd_valid && cmd_ready;
  assign push       = wr_valid && wr_ready;
  assign want_word  = (state_q == StReq) && dir_wr_q && ctl_in_req && (sent_q < ctl_length_q);
  assign pop        = want_word && !fifo_empty && !tmo_hit;
  assign starve     = want_word && fifo_empty;
  assign rd_take    = (state_q == StReq) && !dir_wr_q && ctl_out_valid &&
                      (rcvd_q < ctl_length_q);
  assign head       = mem_q[rptr_q];

`ifdef SDRAM_HOST_TIMEOUT_EN
  logic [11:0] wd_q;
  logic [7:0]  remaining;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_q <= '0;
    end else if (accept) begin
      wd_q <= '0;
    end else if (state_q == StReq || state_q == StRelease) begin
      wd_q <= wd_q + 12'd1;
    end
  end

  assign tmo_hit   = (state_q == StReq || state_q == StRelease) && (wd_q == 12'(TMO_CYC - 1));
  assign remaining = ctl_length_q - sent_q;
  // Drop the aborted burst's unsent words, never more than the FIFO holds.
  assign flush_n   = !(tmo_hit && dir_wr_q) ? '0 :
                     (32'(remaining) > 32'(level_q)) ? level_q : LW'(remaining);
`else
  assign tmo_hit = 1'b0;
  assign flush_n = '0;
`endif

  assign level_d = level_q + LW'(push) - LW'(pop) - flush_n;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {wr_mask, wr_data};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept && cmd_len != 8'd0) state_d = StReq;
      StReq:     if (tmo_hit) state_d = StGap;
                 else if (ctl_done) state_d = StRelease;
      StRelease: if (tmo_hit || !ctl_done) state_d = StGap;
      StGap:     if (gap_q == 8'd0) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Out-of-range or starved requests get a fully masked zero word.
  always_comb begin
    ctl_datain = '0;
    ctl_dm     = '0;
    if (state_q == StReq && dir_wr_q) begin
      if (ctl_in_req && (!want_word || fifo_empty)) begin
        ctl_dm = {MW{1'b1}};
      end else begin
        {ctl_dm, ctl_datain} = head;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      sent_q       <= '0;
      rcvd_q       <= '0;
      gap_q        <= '0;
      dir_wr_q     <= 1'b0;
      err_q        <= 1'b0;
      cmd_done_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      ctl_wr_q     <= 1'b0;
      ctl_rd_q     <= 1'b0;
      ctl_addr_q   <= '0;
      ctl_length_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wptr_q     <= wptr_q + WFIFO_AW'(push);
      rptr_q     <= rptr_q + WFIFO_AW'(pop) + WFIFO_AW'(flush_n);
      cmd_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      if (accept) begin
        ctl_addr_q   <= cmd_addr;
        ctl_length_q <= cmd_len;
        dir_wr_q     <= cmd_write;
        sent_q       <= '0;
        rcvd_q       <= '0;
        if (cmd_len != 8'd0) begin
          ctl_wr_q <= cmd_write;
          ctl_rd_q <= !cmd_write;
        end else begin
          cmd_done_q <= 1'b1;
        end
      end
      if (pop) sent_q <= sent_q + 8'd1;
      if (starve) err_q <= 1'b1;
      if (rd_take) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= ctl_dataout;
        rcvd_q     <= rcvd_q + 8'd1;
      end
      if (state_q == StReq && ctl_done) begin
        ctl_wr_q <= 1'b0;
        ctl_rd_q <= 1'b0;
      end
      if (state_q == StRelease && !ctl_done) begin
        cmd_done_q <= 1'b1;
        gap_q      <= 8'(GAP_CYC - 1);
      end
      if (state_q == StGap && gap_q != 8'd0) gap_q <= gap_q - 8'd1;
      if (tmo_hit) begin
        ctl_wr_q   <= 1'b0;
        ctl_rd_q   <= 1'b0;
        err_q      <= 1'b1;
        cmd_done_q <= 1'b1;
        gap_q      <= 8'(GAP_CYC - 1);
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign err        = err_q;
  assign cmd_done   = cmd_done_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign ctl_wr     = ctl_wr_q;
  assign ctl_rd     = ctl_rd_q;
  assign ctl_addr   = ctl_addr_q;
  assign ctl_length = ctl_length_q;

endmodule

// File: tb/tb_sdram_host_port.sv
// Directed bench for sdram_host_port with a small controller model and an expected-value queue.
// Define SDRAM_HOST_TIMEOUT_EN to also exercise the watchdog with TMO_CYC=20.
module tb_sdram_host_port;

  localparam int unsigned DSIZE = 16;
  localparam int unsigned ASIZE = 23;
  localparam int unsigned MW    = DSIZE / 8;
`ifdef SDRAM_HOST_TIMEOUT_EN
  localparam int unsigned TMO   = 20;
`else
  localparam int unsigned TMO   = 4095;
`endif

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [ASIZE-1:0] cmd_addr;
  logic [7:0]       cmd_len;
  logic             wr_valid, wr_ready;
  logic [DSIZE-1:0] wr_data;
  logic [MW-1:0]    wr_mask;
  logic             rd_valid;
  logic [DSIZE-1:0] rd_data;
  logic             cmd_done, busy, err;
  logic [ASIZE-1:0] ctl_addr;
  logic             ctl_wr, ctl_rd;
  logic [7:0]       ctl_length;
  logic [DSIZE-1:0] ctl_datain;
  logic [MW-1:0]    ctl_dm;
  logic             ctl_in_req, ctl_out_valid, ctl_done;
  logic [DSIZE-1:0] ctl_dataout;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  always #5 CLK = ~CLK;

  sdram_host_port #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .WFIFO_AW(8), .GAP_CYC(2), .TMO_CYC(TMO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_data(rd_data), .cmd_done(cmd_done), .busy(busy), .err(err),
    .ctl_addr(ctl_addr), .ctl_wr(ctl_wr), .ctl_rd(ctl_rd), .ctl_length(ctl_length),
    .ctl_datain(ctl_datain), .ctl_dm(ctl_dm), .ctl_in_req(ctl_in_req),
    .ctl_out_valid(ctl_out_valid), .ctl_dataout(ctl_dataout), .ctl_done(ctl_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; samples follow a further 1ns settle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_words(input int n, input logic [15:0] base, input bit masked);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      wr_mask  = masked ? MW'(i) : '0;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic issue(input bit wr, input logic [ASIZE-1:0] a, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    #1;
    chk("cmd_ready_on_offer", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic stream_write(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      ctl_in_req = 1'b1;
      #1;
      if (sb.size() > 0) chk(tag, 32'({ctl_dm, ctl_datain}), sb.pop_front());
      else chk({tag, "_sb_underrun"}, 32'(sb.size()), 32'd1);
      tick();
    end
    ctl_in_req = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    int dones = 0;
    int hi    = 0;
    ctl_done = 1'b1;
    tick();
    chk({tag, "_req_drop"}, 32'(ctl_wr | ctl_rd), 32'd0);
    tick();
    ctl_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cmd_done) dones++;
      if (ctl_wr || ctl_rd) hi++;
    end
    chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
    chk({tag, "_req_low_gap"}, 32'(hi), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    {cmd_valid, cmd_write, wr_valid, ctl_in_req, ctl_out_valid, ctl_done} = '0;
    cmd_addr = '0; cmd_len = '0; wr_data = '0; wr_mask = '0; ctl_dataout = '0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  initial begin
    int strobes;
    do_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_outputs", 32'({busy, err, cmd_done, rd_valid, ctl_wr, ctl_rd}), 32'd0);
    chk("rst_ctl_word", 32'({ctl_dm, ctl_datain, ctl_length}), 32'd0);
    tick();
    RESET_N = 1'b1;
    tick();

    // Write burst of 8 words, unmasked.
    load_words(8, 16'h1000, 1'b0);
    chk("wr_pre_accept_ctl_wr", 32'(ctl_wr), 32'd0);
    issue(1'b1, 23'h000100, 8'd8);
    chk("wr_ctl_wr_rise", 32'(ctl_wr), 32'd1);
    chk("wr_ctl_addr", 32'(ctl_addr), 32'h100);
    chk("wr_ctl_length", 32'(ctl_length), 32'd8);
    chk("wr_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) sb.push_back(32'h1000 + 32'(i));
    stream_write("wr_word", 8);
    ctl_in_req = 1'b1;
    #1;
    chk("wr_extra_req_word", 32'({ctl_dm, ctl_datain}), 32'h3_0000);
    tick();
    ctl_in_req = 1'b0;
    chk("wr_extra_req_no_err", 32'(err), 32'd0);
    finish_cmd("wr");

    // Read burst of 4 while the model returns 6 words.
    issue(1'b0, 23'h000200, 8'd4);
    chk("rd_ctl_rd_rise", 32'(ctl_rd), 32'd1);
    for (int i = 0; i < 4; i++) sb.push_back(32'hA0 + 32'(i));
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      ctl_out_valid = (i < 6);
      ctl_dataout   = 16'hA0 + 16'(i);
      tick();
      if (rd_valid) begin
        strobes++;
        if (sb.size() > 0) chk("rd_word", 32'(rd_data), sb.pop_front());
        else chk("rd_extra_strobe", 32'(rd_valid), 32'd0);
      end
    end
    ctl_out_valid = 1'b0;
    chk("rd_strobes", 32'(strobes), 32'd4);
    finish_cmd("rd");

    // Write offer held until the FIFO holds enough words; masks vary per word.
    load_words(5, 16'h2000, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 23'h000300; cmd_len = 8'd8;
    for (int i = 5; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'h2000 + 16'(i);
      wr_mask  = MW'(i);
      #1;
      chk("hold_cmd_ready_low", 32'(cmd_ready), 32'd0);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("hold_cmd_ready_high", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_ctl_wr", 32'(ctl_wr), 32'd1);
    for (int i = 0; i < 8; i++) sb.push_back({14'd0, 2'(i), 16'h2000 + 16'(i)});
    stream_write("hold_word", 8);
    finish_cmd("hold");

    // Zero-length read completes without controller activity.
    issue(1'b0, 23'h000400, 8'd0);
    chk("zero_done", 32'(cmd_done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_ctl_rd", 32'(ctl_rd), 32'd0);
    tick();
    chk("zero_done_once", 32'(cmd_done), 32'd0);
    chk("zero_busy_after", 32'(busy | ctl_rd), 32'd0);

`ifdef SDRAM_HOST_TIMEOUT_EN
    begin
      int hi = 0;
      int dn = 0;
      load_words(8, 16'h3000, 1'b0);
      issue(1'b1, 23'h000500, 8'd8);
      for (int k = 0; k < 40; k++) begin
        if (ctl_wr) hi++;
        if (cmd_done) dn++;
        tick();
      end
      chk("tmo_req_cycles", 32'(hi), 32'd20);
      chk("tmo_done_pulses", 32'(dn), 32'd1);
      chk("tmo_err", 32'(err), 32'd1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = 8'd1;
      #1;
      chk("tmo_fifo_flushed", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      tick();
    end
`endif

    // Starved write: FIFO emptied behind the DUT's back.
    do_reset();
    load_words(8, 16'h4000, 1'b0);
    issue(1'b1, 23'h000600, 8'd8);
    force dut.level_q = '0;
    tick();
    release dut.level_q;
    ctl_in_req = 1'b1;
    #1;
    chk("starve_err_before", 32'(err), 32'd0);
    chk("starve_word", 32'({ctl_dm, ctl_datain}), 32'h3_0000);
    tick();
    ctl_in_req = 1'b0;
    chk("starve_err", 32'(err), 32'd1);

    // Asynchronous reset mid-burst.
    RESET_N = 1'b0;
    #1;
    chk("abort_outputs", 32'({ctl_wr, busy, err}), 32'd0);
    chk("abort_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    RESET_N = 1'b1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
